hanoi_move_gen: RTL and testbench

- Upstream stimulus stage for the hanoi rod model.
- Generates the optimal 2^S-1 move sequence that relocates an S-disk tower from rod0 to rod2.
- Presents one (fr, to) move per handshake on a valid/ready interface, with start/busy/done control.
- Drives the model's fr/to inputs in closed-loop simulation and in the formal harness.

---
 rtl/hanoi_pkg.sv | 30 +++
 rtl/hanoi_mod3.sv | 33 +++
 rtl/hanoi_move_gen.sv | 182 ++++++++++++++++++
 tb/tb_hanoi_move_gen.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hanoi_pkg.sv
// rtl/hanoi_pkg.sv - shared types and helpers for the hanoi move generator
// Contents:
//   rod_t       - rod identifier (ROD0..ROD2)
//   gen_state_t - generator state (IDLE, RUN, DONE)
//   swap12      - exchanges rods 1 and 2, leaves rod 0 alone
package hanoi_pkg;

    typedef enum logic [1:0] {
        ROD0 = 2'd0,
        ROD1 = 2'd1,
        ROD2 = 2'd2
    } rod_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gen_state_t;

    // The raw move formula always sends an odd-sized tower to rod2.
    // An even-sized tower needs rods 1 and 2 exchanged to land on rod2.
    function automatic rod_t swap12(rod_t r);
        case (r)
            ROD1:    return ROD2;
            ROD2:    return ROD1;
            default: return r;
        endcase
    endfunction

endpackage

// File: rtl/hanoi_mod3.sv
// rtl/hanoi_mod3.sv - combinational unsigned modulo-3 reduction
// Parameters:
//   W - width of the operand
// Ports:
//   v - W-bit unsigned operand
//   r - v mod 3 (0, 1 or 2)
module hanoi_mod3 #(
    parameter int W = 5
) (
    input  logic [W-1:0] v,
    output logic [1:0]   r
);

    logic [1:0] acc;
    logic [2:0] tmp;

    // Horner evaluation from the MSB: acc = (2*acc + bit) mod 3.
    // tmp never exceeds 5, so a single conditional subtract suffices.
    always_comb begin
        acc = 2'd0;
        tmp = 3'd0;
        for (int i = W - 1; i >= 0; i--) begin
            tmp = {acc, v[i]};
            if (tmp >= 3'd3) begin
                acc = 2'(tmp - 3'd3);
            end else begin
                acc = tmp[1:0];
            end
        end
        r = acc;
    end

endmodule

// File: rtl/hanoi_move_gen.sv
// rtl/hanoi_move_gen.sv - optimal tower-of-hanoi move sequence generator
// Parameters:
//   S - number of disks (1..16); the sequence has 2^S-1 moves
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - begin a new sequence (honoured in IDLE or DONE)
//   mv_valid - fr/to carry a valid move
//   mv_ready - consumer accepts the move
//   fr, to   - source / destination rod of the current move
//   move_cnt - moves transferred since the last start (saturating)
//   busy     - sequence in progress
//   done     - sequence complete, held until the next start
//   err      - sticky legality error from the shadow rod checker
// Optional build macro:
//   HANOI_CHECK_EN - enables the shadow rod checker; otherwise err is 0
module hanoi_move_gen
    import hanoi_pkg::*;
#(
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         mv_valid,
    input  logic         mv_ready,
    output logic [1:0]   fr,
    output logic [1:0]   to,
    output logic [S-1:0] move_cnt,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [S:0]   K_ONE   = (S+1)'(1);
    localparam logic [S:0]   K_LAST  = {1'b0, {S{1'b1}}};
    localparam logic [S-1:0] CNT_MAX = {S{1'b1}};
    localparam bit           S_EVEN  = (S % 2) == 0;

    gen_state_t state;
    logic [S:0] k;
    logic [S:0] k_nx;
    logic [S:0] f_arg;
    logic [S:0] t_arg;
    logic [1:0] f_mod;
    logic [1:0] t_mod;
    rod_t       fr_nx;
    rod_t       to_nx;
    logic       xfer;
    logic       launch;

    assign xfer   = mv_valid & mv_ready;
    assign launch = start & (state != RUN);

    // Index of the move to register at the next edge: a launch always
    // begins at move 1, otherwise it is the successor of the current move.
    assign k_nx  = launch ? K_ONE : (k + K_ONE);
    assign f_arg = k_nx & (k_nx - K_ONE);
    assign t_arg = (k_nx | (k_nx - K_ONE)) + K_ONE;

    hanoi_mod3 #(.W(S + 1)) u_mod3_f (
        .v (f_arg),
        .r (f_mod)
    );

    hanoi_mod3 #(.W(S + 1)) u_mod3_t (
        .v (t_arg),
        .r (t_mod)
    );

    always_comb begin
        fr_nx = rod_t'(f_mod);
        to_nx = rod_t'(t_mod);
        if (S_EVEN) begin
            fr_nx = swap12(rod_t'(f_mod));
            to_nx = swap12(rod_t'(t_mod));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k        <= '0;
            fr       <= 2'd0;
            to       <= 2'd0;
            mv_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            move_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        k        <= K_ONE;
                        fr       <= fr_nx;
                        to       <= to_nx;
                        mv_valid <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        move_cnt <= '0;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (move_cnt != CNT_MAX) begin
                            move_cnt <= move_cnt + 1'b1;
                        end
                        if (k == K_LAST) begin
                            // fr/to deliberately keep the final move
                            state    <= DONE;
                            mv_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            k  <= k_nx;
                            fr <= fr_nx;
                            to <= to_nx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HANOI_CHECK_EN
    localparam logic [S-1:0] ALL_DISKS = {S{1'b1}};

    // Bit i of a rod word is set when disk i sits on that rod; disk 0 is
    // the smallest, so the top disk is the lowest set bit.
    logic [S-1:0] rod [0:2];
    logic [S-1:0] src;
    logic [S-1:0] dst;
    logic [S-1:0] moved;
    logic [S-1:0] dst_top;
    logic [S-1:0] src_nx;
    logic [S-1:0] dst_nx;
    logic [S-1:0] rod2_nx;
    logic         bad_move;

    always_comb begin
        src      = rod[fr];
        dst      = rod[to];
        moved    = src & (~src + 1'b1);
        dst_top  = dst & (~dst + 1'b1);
        src_nx   = src & ~moved;
        dst_nx   = dst | moved;
        bad_move = (src == '0) || ((dst != '0) && (dst_top < moved));
        if (to == 2'd2) begin
            rod2_nx = dst_nx;
        end else if (fr == 2'd2) begin
            rod2_nx = src_nx;
        end else begin
            rod2_nx = rod[2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rod[0] <= ALL_DISKS;
            rod[1] <= '0;
            rod[2] <= '0;
            err    <= 1'b0;
        end else if (launch) begin
            rod[0] <= ALL_DISKS;
            rod[1] <= '0;
            rod[2] <= '0;
            err    <= 1'b0;
        end else if (xfer) begin
            rod[fr] <= src_nx;
            rod[to] <= dst_nx;
            if (bad_move || ((k == K_LAST) && (rod2_nx != ALL_DISKS))) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hanoi_move_gen.sv
// tb/tb_hanoi_move_gen.sv - self-checking bench for hanoi_move_gen (S = 4, 3, 1)
module tb_hanoi_move_gen;

    logic clk;
    logic rst_n;
    logic start;
    logic mv_ready;

    logic       o_valid [3];
    logic       o_busy  [3];
    logic       o_done  [3];
    logic       o_err   [3];
    logic [1:0] o_fr    [3];
    logic [1:0] o_to    [3];
    logic [3:0] c0;
    logic [2:0] c1;
    logic [0:0] c2;
    int         o_cnt   [3];

    always_comb begin
        o_cnt[0] = int'(c0);
        o_cnt[1] = int'(c1);
        o_cnt[2] = int'(c2);
    end

    hanoi_move_gen #(.S(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mv_valid(o_valid[0]), .mv_ready(mv_ready),
        .fr(o_fr[0]), .to(o_to[0]), .move_cnt(c0),
        .busy(o_busy[0]), .done(o_done[0]), .err(o_err[0])
    );

    hanoi_move_gen #(.S(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mv_valid(o_valid[1]), .mv_ready(mv_ready),
        .fr(o_fr[1]), .to(o_to[1]), .move_cnt(c1),
        .busy(o_busy[1]), .done(o_done[1]), .err(o_err[1])
    );

    hanoi_move_gen #(.S(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mv_valid(o_valid[2]), .mv_ready(mv_ready),
        .fr(o_fr[2]), .to(o_to[2]), .move_cnt(c2),
        .busy(o_busy[2]), .done(o_done[2]), .err(o_err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    // Expected move lists built by playing the puzzle on explicit stacks.
    int exp_fr [3][16];
    int exp_to [3][16];
    int nm     [3];

    int m_run  [3];
    int m_done [3];
    int m_cnt  [3];
    int m_fr   [3];
    int m_to   [3];

    int cap_fr [3][16];
    int cap_to [3][16];
    int cap_n  [3];

    typedef struct {
        int d;
        int k;
        int fr;
        int to;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Iterative solution: on even steps the smallest disk advances one rod
    // in a fixed direction; on odd steps the only other legal move is made.
    function automatic void gen_moves(input int d, input int n);
        int pg [3][16];
        int h  [3];
        int sp, step, a, b, tmp, total;
        h = '{n, 0, 0};
        for (int i = 0; i < n; i++) pg[0][i] = n - 1 - i;
        sp    = 0;
        step  = (n % 2 == 1) ? 2 : 1;
        total = (1 << n) - 1;
        for (int m = 0; m < total; m++) begin
            if (m % 2 == 0) begin
                a  = sp;
                b  = (sp + step) % 3;
                sp = b;
            end else begin
                a = (sp + 1) % 3;
                b = (sp + 2) % 3;
                if (h[a] == 0 || (h[b] != 0 && pg[b][h[b]-1] < pg[a][h[a]-1])) begin
                    tmp = a; a = b; b = tmp;
                end
            end
            pg[b][h[b]] = pg[a][h[a]-1];
            h[b] = h[b] + 1;
            h[a] = h[a] - 1;
            exp_fr[d][m] = a;
            exp_to[d][m] = b;
        end
        nm[d] = total;
    endfunction

    // Cycle-level reference: start/transfer/done behaviour over the move list.
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                m_run[d]  <= 0;
                m_done[d] <= 0;
                m_cnt[d]  <= 0;
                m_fr[d]   <= 0;
                m_to[d]   <= 0;
            end else if (m_run[d] == 0) begin
                if (start) begin
                    m_run[d]  <= 1;
                    m_done[d] <= 0;
                    m_cnt[d]  <= 0;
                    m_fr[d]   <= exp_fr[d][0];
                    m_to[d]   <= exp_to[d][0];
                end
            end else if (mv_ready) begin
                m_cnt[d] <= m_cnt[d] + 1;
                if (m_cnt[d] + 1 == nm[d]) begin
                    m_run[d]  <= 0;
                    m_done[d] <= 1;
                end else begin
                    m_fr[d] <= exp_fr[d][m_cnt[d] + 1];
                    m_to[d] <= exp_to[d][m_cnt[d] + 1];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("d%0d valid", d), int'(o_valid[d]), m_run[d]);
                chk($sformatf("d%0d busy", d), int'(o_busy[d]), m_run[d]);
                chk($sformatf("d%0d done", d), int'(o_done[d]), m_done[d]);
                chk($sformatf("d%0d move_cnt", d), o_cnt[d], m_cnt[d]);
                chk($sformatf("d%0d fr", d), int'(o_fr[d]), m_fr[d]);
                chk($sformatf("d%0d to", d), int'(o_to[d]), m_to[d]);
                chk($sformatf("d%0d err", d), int'(o_err[d]), 0);
                if (o_valid[d] && mv_ready && cap_n[d] < 16) begin
                    cap_fr[d][cap_n[d]] = int'(o_fr[d]);
                    cap_to[d][cap_n[d]] = int'(o_to[d]);
                    cap_n[d] = cap_n[d] + 1;
                end
            end
        end
    end

    task automatic clear_caps();
        for (int d = 0; d < 3; d++) cap_n[d] = 0;
    endtask

    task automatic check_reset(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s d%0d valid", tag, d), int'(o_valid[d]), 0);
            chk($sformatf("%s d%0d busy", tag, d), int'(o_busy[d]), 0);
            chk($sformatf("%s d%0d done", tag, d), int'(o_done[d]), 0);
            chk($sformatf("%s d%0d err", tag, d), int'(o_err[d]), 0);
            chk($sformatf("%s d%0d fr", tag, d), int'(o_fr[d]), 0);
            chk($sformatf("%s d%0d to", tag, d), int'(o_to[d]), 0);
            chk($sformatf("%s d%0d cnt", tag, d), o_cnt[d], 0);
        end
    endtask

    task automatic apply_table(input string tag);
        chk($sformatf("%s n0", tag), cap_n[0], 15);
        chk($sformatf("%s n1", tag), cap_n[1], 7);
        chk($sformatf("%s n2", tag), cap_n[2], 1);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("%s tbl%0d fr", tag, i), cap_fr[tbl[i].d][tbl[i].k-1], tbl[i].fr);
            chk($sformatf("%s tbl%0d to", tag, i), cap_to[tbl[i].d][tbl[i].k-1], tbl[i].to);
        end
        chk($sformatf("%s cnt0", tag), o_cnt[0], 15);
        chk($sformatf("%s cnt1", tag), o_cnt[1], 7);
        chk($sformatf("%s cnt2", tag), o_cnt[2], 1);
        chk($sformatf("%s done0", tag), int'(o_done[0]), 1);
        chk($sformatf("%s err0", tag), int'(o_err[0]), 0);
    endtask

    task automatic wait_done0(input string tag);
        for (int i = 0; i < 60 && !o_done[0]; i++) tick();
        chk($sformatf("%s reached done", tag), int'(o_done[0]), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 1, 0, 1};
        tbl[1]  = '{0, 2, 0, 2};
        tbl[2]  = '{0, 3, 1, 2};
        tbl[3]  = '{0, 15, 1, 2};
        tbl[4]  = '{1, 1, 0, 2};
        tbl[5]  = '{1, 2, 0, 1};
        tbl[6]  = '{1, 3, 2, 1};
        tbl[7]  = '{1, 4, 0, 2};
        tbl[8]  = '{1, 5, 1, 0};
        tbl[9]  = '{1, 6, 1, 2};
        tbl[10] = '{1, 7, 0, 2};
        tbl[11] = '{2, 1, 0, 2};

        gen_moves(0, 4);
        gen_moves(1, 3);
        gen_moves(2, 1);
        clear_caps();

        rst_n    = 1'b0;
        start    = 1'b0;
        mv_ready = 1'b0;
        tick();
        tick();
        check_reset("reset");
        rst_n  = 1'b1;
        mon_on = 1'b1;
        tick();

        // back-to-back sequence with mv_ready held high
        mv_ready = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("latency valid", int'(o_valid[0]), 1);
        chk("latency busy", int'(o_busy[0]), 1);
        chk("latency fr", int'(o_fr[0]), 0);
        chk("latency to", int'(o_to[0]), 1);
        chk("latency cnt", o_cnt[0], 0);
        wait_done0("b2b");
        tick();
        apply_table("b2b");

        // stalls with mv_ready pattern 1,0,0,1
        clear_caps();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 120 && !o_done[0]; c++) begin
            mv_ready = (c % 4 == 0) || (c % 4 == 3);
            tick();
        end
        chk("stall reached done", int'(o_done[0]), 1);
        apply_table("stall");

        // start during RUN is ignored, start in DONE restarts
        mv_ready = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done0("run-start");
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart done", int'(o_done[0]), 0);
        chk("restart valid", int'(o_valid[0]), 1);
        chk("restart fr", int'(o_fr[0]), 0);
        chk("restart to", int'(o_to[0]), 1);

        // asynchronous reset after five transfers
        for (int i = 0; i < 5; i++) tick();
        chk("pre-reset cnt", o_cnt[0], 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async");
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post-reset valid", int'(o_valid[0]), 1);
        chk("post-reset fr", int'(o_fr[0]), 0);
        chk("post-reset to", int'(o_to[0]), 1);
        chk("post-reset cnt", o_cnt[0], 0);

        // randomized ready and start
        for (int i = 0; i < 400; i++) begin
            mv_ready = 1'($urandom_range(0, 1));
            start    = ($urandom_range(0, 15) == 0);
            tick();
        end
        start    = 1'b0;
        mv_ready = 1'b1;
        wait_done0("random");
        tick();

`ifdef HANOI_CHECK_EN
        // forced illegal move: raw t forced so the first two moves both land on rod2
        mon_on   = 1'b0;
        mv_ready = 1'b0;
        force dut0.u_mod3_t.r = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        release dut0.u_mod3_t.r;
        chk("fault first to", int'(o_to[0]), 2);
        mv_ready = 1'b1;
        tick();
        chk("fault err clear after legal", int'(o_err[0]), 0);
        tick();
        chk("fault err set", int'(o_err[0]), 1);
        mv_ready = 1'b0;
        tick();
        tick();
        chk("fault err sticky", int'(o_err[0]), 1);
        mv_ready = 1'b1;
        wait_done0("fault");
        chk("fault err at done", int'(o_err[0]), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fault err cleared", int'(o_err[0]), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
